mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the core's data bus, alongside the data memory and the display register. Core stores to the DATA register push bytes into a small FIFO, and the block serialises them as 8N1 frames on o_tx. STATUS and DIVISOR are readable with the same one-cycle read latency as data memory. The top level muxes o_rd_data onto the core read path whenever the registered address hit (o_sel, delayed by one cycle) is set.

---
 rtl/risc16_mmio_pkg.sv | 25 ++
 rtl/mmio_fifo.sv | 65 ++++++
 rtl/mmio_uart_tx.sv | 194 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/risc16_mmio_pkg.sv
// rtl/risc16_mmio_pkg.sv - shared constants and types for the memory-mapped UART transmitter
//
// Purpose : register offsets relative to the base address, STATUS bit
//           positions and the transmitter FSM state type.
// Ports   : none (package).
package risc16_mmio_pkg;

    localparam logic [1:0] OFS_DATA   = 2'd0;
    localparam logic [1:0] OFS_STATUS = 2'd1;
    localparam logic [1:0] OFS_DIV    = 2'd2;

    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/mmio_fifo.sv
// rtl/mmio_fifo.sv - synchronous byte FIFO feeding the UART transmitter
//
// Purpose : DEPTH x 8-bit FIFO with first-word fall-through read data.
// Ports   : clk, rst_n (async, active low), push/wdata (write side),
//           pop/rdata (read side), full, empty, count (0..DEPTH).
module mmio_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [7:0]                   wdata,
    input  logic                         pop,
    output logic [7:0]                   rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    // Fullness is judged on the pre-edge count, so a push into a full FIFO
    // is dropped even when a pop frees a slot on the same edge.
    assign wr_ok = push && !full;
    assign rd_ok = pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are exactly log2(DEPTH) bits so they wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with byte FIFO
//
// Purpose : decodes DATA/STATUS/DIVISOR on the core data bus, queues bytes
//           in mmio_fifo and serialises them LSB first on o_tx.
// Ports   : i_clk, i_rst_n (async, active low); i_addr, i_wr_en, i_wr_data
//           (core store side); o_rd_data (read data, one cycle latency);
//           o_sel (combinational address hit); o_tx (serial line, idles
//           high); o_busy (frame in progress or bytes queued).
module mmio_uart_tx
    import risc16_mmio_pkg::*;
#(
    parameter logic [15:0] p_BASE_ADDR  = 16'hFFFC,
    parameter int unsigned p_CLK_DIV    = 434,
    parameter int          p_FIFO_DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_addr,
    input  logic        i_wr_en,
    input  logic [15:0] i_wr_data,
    output logic [15:0] o_rd_data,
    output logic        o_sel,
    output logic        o_tx,
    output logic        o_busy
);

    localparam int CW = $clog2(p_FIFO_DEPTH + 1);

    // Bus decode: the subtraction wraps addresses below the base to large
    // values, so a single compare covers base..base+2 and excludes base+3.
    logic [15:0] ofs;
    logic        hit;
    logic        wr_data_reg;
    logic        wr_status_reg;
    logic        wr_div_reg;

    assign ofs           = i_addr - p_BASE_ADDR;
    assign hit           = (ofs < 16'd3);
    assign o_sel         = hit;
    assign wr_data_reg   = i_wr_en && hit && (ofs[1:0] == OFS_DATA);
    assign wr_status_reg = i_wr_en && hit && (ofs[1:0] == OFS_STATUS);
    assign wr_div_reg    = i_wr_en && hit && (ofs[1:0] == OFS_DIV);

    // FIFO
    logic          pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    mmio_fifo #(
        .DEPTH (p_FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (wr_data_reg),
        .wdata (i_wr_data[7:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Register file
    logic [15:0] div_q;
    logic        ovf_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_q <= 16'(p_CLK_DIV);
            ovf_q <= 1'b0;
        end else begin
            if (wr_div_reg) begin
                div_q <= (i_wr_data == 16'd0) ? 16'd1 : i_wr_data;
            end
            if (wr_data_reg && fifo_full) begin
                ovf_q <= 1'b1;
            end else if (wr_status_reg && i_wr_data[ST_OVF]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // TX FSM
    tx_state_e   state_q;
    tx_state_e   state_d;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        bit_done;

    assign bit_done = (bit_cnt == 16'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        o_tx    = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                o_tx = 1'b0;
                if (bit_done) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                o_tx = shreg[0];
                if (bit_done && (bit_idx == 3'd7)) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Baud counter and shift register. A reload always samples the current
    // DIVISOR, so a mid-frame divisor write only shortens/lengthens later bits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
        end else if (pop) begin
            shreg   <= fifo_rdata;
            bit_cnt <= div_q - 16'd1;
            bit_idx <= 3'd0;
        end else if (state_q != S_IDLE) begin
            if (bit_done) begin
                bit_cnt <= div_q - 16'd1;
                if (state_q == S_DATA) begin
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                bit_cnt <= bit_cnt - 16'd1;
            end
        end
    end

    assign o_busy = (state_q != S_IDLE) || !fifo_empty;

    // Read path
    logic [15:0] rd_val;

    always_comb begin
        rd_val = 16'd0;
        if (hit) begin
            case (ofs[1:0])
                OFS_STATUS: begin
                    rd_val[ST_BUSY]                    = (state_q != S_IDLE);
                    rd_val[ST_FULL]                    = fifo_full;
                    rd_val[ST_EMPTY]                   = fifo_empty;
                    rd_val[ST_OVF]                     = ovf_q;
                    rd_val[ST_COUNT_LSB+3:ST_COUNT_LSB] = 4'(fifo_count);
                end
                OFS_DIV:  rd_val = div_q;
                default:  rd_val = 16'd0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_data <= 16'd0;
        end else begin
            o_rd_data <= rd_val;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;

    localparam logic [15:0] A_DATA = 16'hFFFC;
    localparam logic [15:0] A_STAT = 16'hFFFD;
    localparam logic [15:0] A_DIV  = 16'hFFFE;
    localparam logic [15:0] A_RSVD = 16'hFFFF;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [15:0] i_addr = 16'd0;
    logic        i_wr_en = 1'b0;
    logic [15:0] i_wr_data = 16'd0;
    logic [15:0] o_rd_data;
    logic        o_sel;
    logic        o_tx;
    logic        o_busy;

    int errors = 0;
    int checks = 0;

    logic [1:0] cap_q[$];
    logic [1:0] exp_q[$];
    logic       cap_en = 1'b0;

    mmio_uart_tx dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_addr    (i_addr),
        .i_wr_en   (i_wr_en),
        .i_wr_data (i_wr_data),
        .o_rd_data (o_rd_data),
        .o_sel     (o_sel),
        .o_tx      (o_tx),
        .o_busy    (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // {busy, tx} sampled mid-cycle while a capture window is open.
    always @(negedge i_clk) begin
        if (cap_en) cap_q.push_back({o_busy, o_tx});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        i_addr    = addr;
        i_wr_data = data;
        i_wr_en   = 1'b1;
        tick();
        i_wr_en   = 1'b0;
        i_addr    = 16'd0;
    endtask

    task automatic rd(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        i_addr = addr;
        tick();
        i_addr = 16'd0;
        chk(tag, o_rd_data, exp);
    endtask

    // Reference line model: each bit of an 8N1 frame is div cycles long.
    task automatic add_bits(input logic busy, input logic tx, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back({busy, tx});
    endtask

    task automatic add_frame(input logic [7:0] b, input int div);
        add_bits(1'b1, 1'b0, div);
        for (int k = 0; k < 8; k++) add_bits(1'b1, b[k], div);
        add_bits(1'b1, 1'b1, div);
    endtask

    // Called right after the DATA write that starts a run: the first sample
    // is the idle cycle between the write edge and the start bit.
    task automatic start_capture();
        cap_q.delete();
        exp_q.delete();
        add_bits(1'b1, 1'b1, 1);
        cap_en = 1'b1;
    endtask

    task automatic finish_capture(input string tag);
        int n;
        add_bits(1'b0, 1'b1, 3);
        n = exp_q.size();
        for (int t = 0; t < 20000 && cap_q.size() < n; t++) @(posedge i_clk);
        #1;
        cap_en = 1'b0;
        chk({tag, "_len"}, cap_q.size(), n);
        for (int k = 0; k < n && k < cap_q.size(); k++)
            chk($sformatf("%s[%0d]", tag, k), cap_q[k], exp_q[k]);
    endtask

    initial begin
        logic [7:0] rb [$];
        int         div;
        int         n;

        // 1: reset values and decode
        #12;
        chk("reset_tx", o_tx, 1'b1);
        chk("reset_rd", o_rd_data, 16'd0);
        chk("reset_busy", o_busy, 1'b0);
        i_rst_n = 1'b1;
        tick();
        rd("t1_status", A_STAT, 16'h0004);
        rd("t1_div", A_DIV, 16'd434);
        rd("t1_data_rd", A_DATA, 16'h0000);
        rd("t1_rsvd_rd", A_RSVD, 16'h0000);
        i_addr = A_DIV;  #1; chk("sel_div", o_sel, 1'b1);
        i_addr = A_DATA; #1; chk("sel_data", o_sel, 1'b1);
        i_addr = A_RSVD; #1; chk("sel_rsvd", o_sel, 1'b0);
        i_addr = 16'hFFFB; #1; chk("sel_below", o_sel, 1'b0);
        i_addr = 16'd0;
        chk("t1_tx", o_tx, 1'b1);

        // 2: single frame at divisor 4, upper data bits ignored
        wr(A_DIV, 16'd4);
        wr(A_DATA, 16'hAB55);
        start_capture();
        add_frame(8'h55, 4);
        finish_capture("t2");

        // 3: fill FIFO, overflow, back-to-back frames
        wr(A_DIV, 16'd2);
        wr(A_DATA, 16'h0001);
        start_capture();
        for (int k = 2; k <= 9; k++) wr(A_DATA, 16'(k));
        rd("t3_full", A_STAT, 16'h0083);
        wr(A_DATA, 16'h000A);
        rd("t3_ovf", A_STAT, 16'h008B);
        for (int k = 1; k <= 9; k++) add_frame(8'(k), 2);
        finish_capture("t3");

        // 4: overflow clears only via bit 3
        rd("t4_before", A_STAT, 16'h000C);
        wr(A_STAT, 16'hFFF7);
        rd("t4_keep", A_STAT, 16'h000C);
        wr(A_STAT, 16'h0008);
        rd("t4_clear", A_STAT, 16'h0004);
        rd("t4_div", A_DIV, 16'd2);

        // divisor 0 is stored as 1
        wr(A_DIV, 16'd0);
        rd("div_zero", A_DIV, 16'd1);

        // 5: divisor change during data bit 2
        wr(A_DIV, 16'd8);
        wr(A_DATA, 16'h0055);
        start_capture();
        repeat (27) tick();
        wr(A_DIV, 16'd2);
        add_bits(1'b1, 1'b0, 8);
        for (int k = 0; k < 8; k++) add_bits(1'b1, k[0] ? 1'b0 : 1'b1, (k <= 2) ? 8 : 2);
        add_bits(1'b1, 1'b1, 2);
        finish_capture("t5");

        // randomized bursts against the line model
        for (int it = 0; it < 4; it++) begin
            div = int'($urandom_range(1, 3));
            n   = int'($urandom_range(1, 8));
            rb.delete();
            for (int k = 0; k < n; k++) rb.push_back(8'($urandom));
            wr(A_DIV, 16'(div));
            wr(A_DATA, {8'($urandom), rb[0]});
            start_capture();
            for (int k = 1; k < n; k++) wr(A_DATA, {8'($urandom), rb[k]});
            for (int k = 0; k < n; k++) add_frame(rb[k], div);
            finish_capture($sformatf("rnd%0d", it));
            rd($sformatf("rnd%0d_stat", it), A_STAT, 16'h0004);
        end

        // 6: asynchronous reset mid-frame
        wr(A_DIV, 16'd100);
        wr(A_DATA, 16'h003C);
        tick();
        tick();
        chk("t6_start", o_tx, 1'b0);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("t6_async_tx", o_tx, 1'b1);
        chk("t6_async_busy", o_busy, 1'b0);
        tick();
        i_rst_n = 1'b1;
        tick();
        chk("t6_idle_tx", o_tx, 1'b1);
        rd("t6_status", A_STAT, 16'h0004);
        rd("t6_div", A_DIV, 16'd434);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
